// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Hazard and sequencing control for a 5-stage RISC-V pipeline.
//               Decodes the ID instruction, tracks EX/MEM/WB destinations in
//               a shadow scoreboard, and drives the stall, flush and EX
//               forwarding selects. Handles load-use stalls, taken-branch
//               flushes and data-memory wait states with a sticky timeout.
// Options     : HAZARD_PERF_CNT_EN - builds the stall/flush perf counters;
//               when undefined both counter ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      InstrD,
    input  logic             pcsrc_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ready_m,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] c_max_wait = WCNT_W'(MAX_WAIT);
    localparam logic [WCNT_W-1:0] c_wait_one = WCNT_W'(1);

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    // Scoreboard: EX entry carries sources for forwarding, MEM/WB carry dests
    logic [4:0] e_rd_q, e_rd_d;
    logic       e_regwrite_q, e_regwrite_d;
    logic       e_load_q, e_load_d;
    logic [4:0] e_rs1_q, e_rs1_d;
    logic [4:0] e_rs2_q, e_rs2_d;
    logic [4:0] m_rd_q, m_rd_d;
    logic       m_regwrite_q, m_regwrite_d;
    logic [4:0] w_rd_q, w_rd_d;
    logic       w_regwrite_q, w_regwrite_d;

    logic [6:0] w_opcode;
    logic [4:0] w_rs1, w_rs2, w_rd;
    logic       w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;
    logic       w_mem_wait, w_load_use;
    logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic       w_flush_d, w_flush_e, w_flush_w;
    logic [1:0] w_fwd_a, w_fwd_b;

    // Funct and immediate-high fields play no part in hazard decisions
    logic unused_instr_bits;
    assign unused_instr_bits = ^{InstrD[31:25], InstrD[14:12]};

    // Decode which register fields of the ID instruction are live
    always_comb begin
        w_opcode    = InstrD[6:0];
        w_rd        = InstrD[11:7];
        w_rs1       = InstrD[19:15];
        w_rs2       = InstrD[24:20];
        w_uses_rs1  = w_opcode inside {c_op_rtype, c_op_itype, c_op_load,
                                       c_op_store, c_op_branch, c_op_jalr};
        w_uses_rs2  = w_opcode inside {c_op_rtype, c_op_store, c_op_branch};
        w_writes_rd = w_opcode inside {c_op_rtype, c_op_itype, c_op_load,
                                       c_op_jal, c_op_jalr, c_op_lui,
                                       c_op_auipc};
        w_is_load   = (w_opcode == c_op_load);
    end

    // Memory-wait FSM, wait counter and sticky timeout
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        w_mem_wait    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (dmem_req_m && !dmem_ready_m) begin
                    w_mem_wait = 1'b1;
                    state_d    = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (dmem_ready_m) begin
                    state_d = ST_RUN;
                end else begin
                    w_mem_wait = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Every stalled wait-state cycle (including the entry cycle) counts
        if (w_mem_wait) begin
            wait_cnt_d = (wait_cnt_q == c_max_wait) ? wait_cnt_q
                                                    : wait_cnt_q + c_wait_one;
        end
        if (wait_cnt_d == c_max_wait) begin
            mem_timeout_d = 1'b1;
        end
    end

    // Prioritised stall/flush selection: memory wait > branch > load-use
    always_comb begin
        w_load_use = e_load_q && (e_rd_q != 5'd0) &&
                     ((w_uses_rs1 && (w_rs1 == e_rd_q)) ||
                      (w_uses_rs2 && (w_rs2 == e_rd_q)));
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (w_mem_wait) begin
            // A taken branch in EX is frozen with EX and resolves after release
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (pcsrc_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // EX operand forwarding, MEM result preferred over WB
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (m_regwrite_q && (m_rd_q != 5'd0) && (m_rd_q == e_rs1_q)) begin
            w_fwd_a = 2'b10;
        end else if (w_regwrite_q && (w_rd_q != 5'd0) && (w_rd_q == e_rs1_q)) begin
            w_fwd_a = 2'b01;
        end
        if (m_regwrite_q && (m_rd_q != 5'd0) && (m_rd_q == e_rs2_q)) begin
            w_fwd_b = 2'b10;
        end else if (w_regwrite_q && (w_rd_q != 5'd0) && (w_rd_q == e_rs2_q)) begin
            w_fwd_b = 2'b01;
        end
    end

    // Scoreboard advance; unused source fields are recorded as x0
    always_comb begin
        e_rd_d       = e_rd_q;
        e_regwrite_d = e_regwrite_q;
        e_load_d     = e_load_q;
        e_rs1_d      = e_rs1_q;
        e_rs2_d      = e_rs2_q;
        m_rd_d       = m_rd_q;
        m_regwrite_d = m_regwrite_q;
        if (!w_stall_e) begin
            if (w_flush_e) begin
                e_rd_d       = 5'd0;
                e_regwrite_d = 1'b0;
                e_load_d     = 1'b0;
                e_rs1_d      = 5'd0;
                e_rs2_d      = 5'd0;
            end else begin
                e_rd_d       = w_rd;
                e_regwrite_d = w_writes_rd;
                e_load_d     = w_is_load;
                e_rs1_d      = w_uses_rs1 ? w_rs1 : 5'd0;
                e_rs2_d      = w_uses_rs2 ? w_rs2 : 5'd0;
            end
        end
        if (!w_stall_m) begin
            m_rd_d       = e_rd_q;
            m_regwrite_d = e_regwrite_q;
        end
        w_rd_d       = w_flush_w ? 5'd0 : m_rd_q;
        w_regwrite_d = w_flush_w ? 1'b0 : m_regwrite_q;
    end

    // State, wait counter, timeout flag and scoreboard registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            e_rd_q        <= 5'd0;
            e_regwrite_q  <= 1'b0;
            e_load_q      <= 1'b0;
            e_rs1_q       <= 5'd0;
            e_rs2_q       <= 5'd0;
            m_rd_q        <= 5'd0;
            m_regwrite_q  <= 1'b0;
            w_rd_q        <= 5'd0;
            w_regwrite_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            e_rd_q        <= e_rd_d;
            e_regwrite_q  <= e_regwrite_d;
            e_load_q      <= e_load_d;
            e_rs1_q       <= e_rs1_d;
            e_rs2_q       <= e_rs2_d;
            m_rd_q        <= m_rd_d;
            m_regwrite_q  <= m_regwrite_d;
            w_rd_q        <= w_rd_d;
            w_regwrite_q  <= w_regwrite_d;
        end
    end

    // Outputs forced low while reset is held, even with live inputs
    assign stallF      = reset & w_stall_f;
    assign stallD      = reset & w_stall_d;
    assign stallE      = reset & w_stall_e;
    assign stallM      = reset & w_stall_m;
    assign flushD      = reset & w_flush_d;
    assign flushE      = reset & w_flush_e;
    assign flushW      = reset & w_flush_w;
    assign forwardAE   = reset ? w_fwd_a : 2'b00;
    assign forwardBE   = reset ? w_fwd_b : 2'b00;
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Free-running, wrapping counts of PC-hold and IF/ID-flush cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stallF) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (flushD) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Self-checking bench for hazard_controller. A behavioural
//               pipeline model (EX/MEM/WB occupancy plus a wait-run length)
//               predicts every output each cycle for directed and random
//               instruction/branch/memory stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      InstrD;
    logic             pcsrc_e, dmem_req_m, dmem_ready_m;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic [1:0]       forwardAE, forwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .pcsrc_e(pcsrc_e),
        .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    // One pipeline slot as seen by the hazard logic
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } slot_t;

    slot_t            ex_s, mem_s, wb_s;
    bit               in_wait;
    int               wait_run;
    bit               exp_timeout;
    logic [CNT_W-1:0] exp_stalls, exp_flushes;
    int               n_checks = 0;
    int               n_pass   = 0;

    logic [6:0] op_pool [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111,
                                 7'b0010111, 7'b0001111};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit writes_rd(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                          7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    // Newest producer of src among MEM (10) then WB (01)
    function automatic logic [1:0] source_of(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (mem_s.wr && mem_s.rd == src) return 2'b10;
        if (wb_s.wr && wb_s.rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        op = op_pool[$urandom_range(9)];
        return {7'($urandom_range(127)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                3'($urandom_range(7)), 5'($urandom_range(3)), op};
    endfunction

    task automatic model_reset();
        ex_s = '0; mem_s = '0; wb_s = '0;
        in_wait = 0; wait_run = 0; exp_timeout = 0;
        exp_stalls = '0; exp_flushes = '0;
    endtask

    // Drive one cycle, compare outputs with the model, then advance the model
    task automatic step(input logic [31:0] ins, input logic pc, input logic rq, input logic rdy);
        slot_t      nxt;
        logic [6:0] op;
        logic [6:0] ctl;
        bit         blocked, lu;
        @(posedge clk); #1;
        InstrD = ins; pcsrc_e = pc; dmem_req_m = rq; dmem_ready_m = rdy;
        #1;
        op      = ins[6:0];
        nxt.rd  = ins[11:7];
        nxt.wr  = writes_rd(op);
        nxt.ld  = (op == 7'b0000011);
        nxt.rs1 = reads_rs1(op) ? ins[19:15] : 5'd0;
        nxt.rs2 = reads_rs2(op) ? ins[24:20] : 5'd0;
        blocked = !rdy && (in_wait || rq);
        lu      = ex_s.ld && ex_s.rd != 5'd0 &&
                  ((reads_rs1(op) && ins[19:15] == ex_s.rd) ||
                   (reads_rs2(op) && ins[24:20] == ex_s.rd));
        // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
        if (blocked)  ctl = 7'b1111001;
        else if (pc)  ctl = 7'b0000110;
        else if (lu)  ctl = 7'b1100010;
        else          ctl = 7'b0000000;
        check("ctl", {25'd0, stallF, stallD, stallE, stallM, flushD, flushE, flushW}, {25'd0, ctl});
        check("fwdA", {30'd0, forwardAE}, {30'd0, source_of(ex_s.rs1)});
        check("fwdB", {30'd0, forwardBE}, {30'd0, source_of(ex_s.rs2)});
        check("timeout", {31'd0, mem_timeout}, {31'd0, exp_timeout});
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cycles, exp_stalls);
        check("flush_cnt", flush_count, exp_flushes);
`else
        check("stall_cnt", stall_cycles, 32'd0);
        check("flush_cnt", flush_count, 32'd0);
`endif
        if (ctl[6]) exp_stalls++;
        if (ctl[2]) exp_flushes++;
        if (blocked) begin
            wb_s = '0;
            wait_run = (wait_run < MAX_WAIT) ? wait_run + 1 : MAX_WAIT;
            if (wait_run >= MAX_WAIT) exp_timeout = 1;
        end else begin
            wb_s  = mem_s;
            mem_s = ex_s;
            ex_s  = ctl[1] ? slot_t'('0) : nxt;
            wait_run = 0;
        end
        in_wait = blocked;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {25'd0, stallF, stallD, stallE, stallM, flushD, flushE, flushW}, 32'd0);
        check({tag, "_fwd"}, {28'd0, forwardAE, forwardBE}, 32'd0);
        check({tag, "_timeout"}, {31'd0, mem_timeout}, 32'd0);
        check({tag, "_cnt"}, stall_cycles | flush_count, 32'd0);
    endtask

    localparam logic [31:0] NOP = 32'h00000013;

    initial begin
        // Reset held with hazard-provoking inputs: outputs must stay low
        reset = 1'b0; InstrD = 32'h00228333; pcsrc_e = 1'b1;
        dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
        model_reset();
        #7;
        check_all_zero("reset");
        pcsrc_e = 1'b0; dmem_req_m = 1'b0; InstrD = NOP;
        @(posedge clk); #1 reset = 1'b1;

        // Load-use: stall one cycle, then WB forward once add reaches EX
        step(32'h0000A283, 0, 0, 0);
        step(32'h00228333, 0, 0, 0);
        step(32'h00228333, 0, 0, 0);
        step(NOP, 0, 0, 0);
        // MEM forwarding on both operands
        step(32'h00508113, 0, 0, 0);
        step(32'h002101B3, 0, 0, 0);
        step(NOP, 0, 0, 0);
        // Branch overriding a pending load-use
        step(32'h0000A283, 0, 0, 0);
        step(32'h00228333, 1, 0, 0);
        step(NOP, 0, 0, 0);
        // Short memory wait, released on ready
        for (int i = 0; i < 3; i++) step(NOP, 0, 1, 0);
        step(NOP, 0, 1, 1);
        // Writes to x0 never create hazards
        step(32'h00002003, 0, 0, 0);
        step(32'h00000333, 0, 0, 0);
        step(NOP, 0, 0, 0);
        step(NOP, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(rand_instr(), $urandom_range(7) == 0, $urandom_range(3) == 0,
                 1'($urandom_range(1)));

        // Long wait crossing the timeout threshold
        for (int i = 0; i < MAX_WAIT + 4; i++) step(rand_instr(), 0, 1, 0);

        // Asynchronous reset in the middle of the wait
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        model_reset();
        pcsrc_e = 1'b0; dmem_req_m = 1'b0; dmem_ready_m = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 300; i++)
            step(rand_instr(), $urandom_range(7) == 0, $urandom_range(3) == 0,
                 1'($urandom_range(1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RISC-V core.
- Decodes the ID-stage instruction and keeps a shadow scoreboard of destination registers in EX/MEM/WB.
- Drives the stall/flush controls of the IF/ID register (en, clr) and of the later pipeline registers, plus EX-stage forwarding selects.
- Handles load-use stalls, taken-branch flushes and data-memory wait states.

Parameters:
MAX_WAIT, 16, memory wait cycles before mem_timeout is raised (>=1)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
InstrD  in  32  instruction currently in ID (IF/ID register output)
pcsrc_e  in  1  branch/jump taken, resolved in EX
dmem_req_m  in  1  MEM-stage data-memory access in progress
dmem_ready_m  in  1  data memory completes access this cycle
stallF  out  1  hold PC
stallD  out  1  hold IF/ID; connects to IF/ID en (1 = hold)
stallE  out  1  hold ID/EX
stallM  out  1  hold EX/MEM
flushD  out  1  clear IF/ID; connects to IF/ID clr
flushE  out  1  bubble into ID/EX
flushW  out  1  bubble into MEM/WB
forwardAE  out  2  rs1 source for EX: 00 regfile, 01 WB result, 10 MEM ALU result
forwardBE  out  2  rs2 source for EX, same encoding
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  performance counter (optional feature)
flush_count  out  CNT_W  performance counter (optional feature)

Behaviour:
- Reset (reset=0, async): FSM=RUN, wait_cnt=0, scoreboard cleared (regwrite=0, rd=0, load=0 in E/M/W), mem_timeout=0, counters=0. All outputs 0 while reset is held.
- Decode of InstrD[6:0]:
  - uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111
  - uses rs2: 0110011, 0100011, 1100011
  - writes rd: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111
  - load: 0000011
  - x0 never matches as a hazard source or destination.
- Scoreboard (registered): E entry holds rd, regwrite, load, rs1, rs2 of the instruction in EX; M and W entries hold rd and regwrite.
  - E loads from the decode when !stallE; loads a bubble (all zero) when flushE && !stallE.
  - M loads from E when !stallM.
  - W loads from M; loads a bubble when flushW.
- FSM states:
  - RUN -> MWAIT when dmem_req_m && !dmem_ready_m. This cycle already asserts the MWAIT outputs combinationally.
  - MWAIT -> RUN on dmem_ready_m. The stall drops in the same cycle ready is seen.
  - In MWAIT, wait_cnt increments each cycle and saturates. When it reaches MAX_WAIT, mem_timeout sets and stays set until reset. The FSM remains in MWAIT.
  - wait_cnt clears on return to RUN.
- Output priority, combinational from FSM, scoreboard, InstrD and inputs:
  1. Memory wait (MWAIT, or entering it): stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0. A concurrent pcsrc_e is held in EX and acts after release.
  2. Else if pcsrc_e: flushD=1, flushE=1, all stalls 0. This overrides load-use.
  3. Else if load-use (E.load && E.rd!=0 && E.rd matches a used rs1D/rs2D): stallF=stallD=1, flushE=1, for exactly one cycle.
  4. Else all stall and flush outputs are 0.
- Forwarding, per operand on E.rs1/E.rs2:
  - 10 if M.regwrite && M.rd!=0 && M.rd==src.
  - Else 01 if W.regwrite && W.rd!=0 && W.rd==src.
  - Else 00. MEM has priority over WB.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments every cycle stallF=1; flush_count increments every cycle flushD=1. Both wrap at 2^CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: lw x5,0(x1) (0x0000A283) followed by add x6,x5,x2 (0x00228333) -> one cycle with stallF=stallD=flushE=1; next cycle all 0 and forwardAE=01 when the add reaches EX.
- Forwarding: addi x2,x1,5 (0x00508113) then add x3,x2,x2 (0x002101B3) -> no stall; forwardAE=forwardBE=10 with the add in EX.
- Branch: pcsrc_e=1 for one cycle with lw-use pending in ID -> flushD=flushE=1, stallF=0, in that cycle only.
- Memory wait: dmem_req_m=1, dmem_ready_m=0 for 3 cycles, then 1 -> stallF..M=1 and flushW=1 for 3 cycles, released on the ready cycle; mem_timeout=0.
- Timeout and reset: hold ready=0 for MAX_WAIT=16 cycles -> mem_timeout=1 and stays 1; pulse reset=0 mid-wait -> all outputs 0 immediately, FSM=RUN.
- x0 writes: lw x0 then add using x0 -> no stall; forward selects 00.
